input_sram_loader: RTL and testbench

Input-feature loader sitting directly upstream of the 8-bank input SRAM block in the accelerator top. On `start` it streams a width × height × channel input feature map from external DRAM, word by word through a valid/ready read port, and writes it into the input SRAM banks row-interleaved, so the SRAM controller downstream finds each row in bank (row mod 8). It issues up to 4 outstanding DRAM reads, tracks one write pointer per bank, and signals `done` when the last word has been written.

---
 rtl/input_sram_loader_if.sv | 30 +++
 rtl/input_sram_loader.sv | 207 ++++++++++++++++++++
 tb/tb_input_sram_loader.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/input_sram_loader_if.sv
// Bus bundle between the input loader and its neighbours: the DRAM read
// request/response port and the banked input SRAM write port.
interface input_sram_loader_if #(
  parameter int BANKS   = 8,
  parameter int DATA_W  = 32,
  parameter int SRAM_AW = 14,
  parameter int DRAM_AW = 32
) ();
  logic               dram_req;
  logic [DRAM_AW-1:0] dram_addr;
  logic               dram_ready;
  logic               dram_rvalid;
  logic [DATA_W-1:0]  dram_rdata;
  logic [BANKS-1:0]   sram_cs;
  logic               sram_we;
  logic [SRAM_AW-1:0] sram_addr;
  logic [DATA_W-1:0]  sram_wdata;

  modport master (
    output dram_req, dram_addr,
    input  dram_ready, dram_rvalid, dram_rdata,
    output sram_cs, sram_we, sram_addr, sram_wdata
  );

  modport slave (
    input  dram_req, dram_addr,
    output dram_ready, dram_rvalid, dram_rdata,
    input  sram_cs, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/input_sram_loader.sv
// Streams a width x height x channel feature map from DRAM into the input SRAM
// banks, placing each row in bank (row mod BANKS) with one write pointer per bank.
module input_sram_loader #(
  parameter int                 BANKS       = 8,
  parameter int                 DATA_W      = 32,
  parameter int                 SRAM_AW     = 14,
  parameter int                 DRAM_AW     = 32,
  parameter logic [DRAM_AW-1:0] INPUT_START = {DRAM_AW{1'b0}},
  parameter int                 MAX_OUTST   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [9:0]          width_i,
  input  logic [9:0]          height_i,
  input  logic [9:0]          channel_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                overflow_o,
  input_sram_loader_if.master bus
);

  localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int OW = $clog2(MAX_OUTST + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [29:0]        total_q;
  logic [29:0]        issued_q;
  logic [29:0]        written_q;
  logic [OW-1:0]      outst_q, outst_d;
  logic [DRAM_AW-1:0] addr_q;
  logic [9:0]         width_q;
  logic [9:0]         height_q;
  logic [9:0]         x_q;
  logic [9:0]         r_q;
  logic [SRAM_AW-1:0] wptr_q [BANKS];
  logic               overflow_q;
  logic               we_q;
  logic [BANKS-1:0]   cs_q;
  logic [SRAM_AW-1:0] saddr_q;
  logic [DATA_W-1:0]  wdata_q;

  logic               start_ok_s;
  logic               dims_zero_s;
  logic [29:0]        total_s;
  logic               req_s;
  logic               accept_s;
  logic               resp_s;
  logic [BW-1:0]      bank_s;
  logic [BANKS-1:0]   onehot_s;

  // Handshake qualification; responses with nothing outstanding are stale and dropped.
  always_comb begin
    start_ok_s  = start_i && (state_q == S_IDLE);
    total_s     = 30'(width_i) * 30'(height_i) * 30'(channel_i);
    dims_zero_s = (width_i == 10'd0) || (height_i == 10'd0) || (channel_i == 10'd0);
    req_s       = (state_q == S_REQ) && (issued_q < total_q) &&
                  (outst_q < OW'(MAX_OUTST));
    accept_s    = req_s && bus.dram_ready;
    resp_s      = bus.dram_rvalid && (outst_q != {OW{1'b0}}) &&
                  ((state_q == S_REQ) || (state_q == S_DRAIN));
    bank_s      = r_q[BW-1:0];
    onehot_s    = {{(BANKS-1){1'b0}}, 1'b1} << bank_s;
  end

  // Outstanding-read bookkeeping: accept and response in one cycle cancel.
  always_comb begin
    outst_d = outst_q;
    if (accept_s && !resp_s) begin
      outst_d = outst_q + OW'(1);
    end else if (!accept_s && resp_s) begin
      outst_d = outst_q - OW'(1);
    end else begin
      outst_d = outst_q;
    end
  end

  // Load sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok_s) begin
          state_d = dims_zero_s ? S_FIN : S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (issued_q == total_q) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        if (written_q == total_q) begin
          state_d = S_FIN;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request side, response-side walk and per-bank write pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      total_q    <= 30'd0;
      issued_q   <= 30'd0;
      written_q  <= 30'd0;
      outst_q    <= {OW{1'b0}};
      addr_q     <= INPUT_START;
      width_q    <= 10'd0;
      height_q   <= 10'd0;
      x_q        <= 10'd0;
      r_q        <= 10'd0;
      overflow_q <= 1'b0;
      for (int b = 0; b < BANKS; b++) begin
        wptr_q[b] <= {SRAM_AW{1'b0}};
      end
    end else if (start_ok_s) begin
      total_q    <= total_s;
      issued_q   <= 30'd0;
      written_q  <= 30'd0;
      outst_q    <= {OW{1'b0}};
      addr_q     <= INPUT_START;
      width_q    <= width_i;
      height_q   <= height_i;
      x_q        <= 10'd0;
      r_q        <= 10'd0;
      overflow_q <= 1'b0;
      for (int b = 0; b < BANKS; b++) begin
        wptr_q[b] <= {SRAM_AW{1'b0}};
      end
    end else begin
      outst_q <= outst_d;
      if (accept_s) begin
        issued_q <= issued_q + 30'd1;
        addr_q   <= addr_q + DRAM_AW'(4);
      end
      if (resp_s) begin
        written_q      <= written_q + 30'd1;
        wptr_q[bank_s] <= wptr_q[bank_s] + SRAM_AW'(1);
        // The write at an all-ones pointer still lands; the pointer then wraps.
        if (&wptr_q[bank_s]) begin
          overflow_q <= 1'b1;
        end
        if (x_q == width_q - 10'd1) begin
          x_q <= 10'd0;
          r_q <= (r_q == height_q - 10'd1) ? 10'd0 : r_q + 10'd1;
        end else begin
          x_q <= x_q + 10'd1;
        end
      end
    end
  end

  // Registered SRAM write port: a response at edge T writes during cycle T+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      cs_q    <= {BANKS{1'b0}};
      saddr_q <= {SRAM_AW{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
    end else begin
      we_q <= resp_s;
      if (resp_s) begin
        cs_q    <= onehot_s;
        saddr_q <= wptr_q[bank_s];
        wdata_q <= bus.dram_rdata;
      end else begin
        cs_q    <= {BANKS{1'b0}};
      end
    end
  end

  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = (state_q == S_FIN);
  assign overflow_o     = overflow_q;
  assign bus.dram_req   = req_s;
  assign bus.dram_addr  = addr_q;
  assign bus.sram_cs    = cs_q;
  assign bus.sram_we    = we_q;
  assign bus.sram_addr  = saddr_q;
  assign bus.sram_wdata = wdata_q;

endmodule

// File: tb/tb_input_sram_loader.sv
// Randomised scoreboard bench for input_sram_loader: a DRAM responder with
// configurable latency/stalls, an SRAM write monitor and a per-word placement model.
module tb_input_sram_loader;
  localparam int          BANKS = 8;
  localparam int          DW    = 32;
  localparam int          SAW   = 14;
  localparam int          DAW   = 32;
  localparam int          MAXO  = 4;
  localparam logic [31:0] BASE  = 32'h0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [9:0] w_i = 10'd0, h_i = 10'd0, c_i = 10'd0;
  logic       busy, done, ovf;

  input_sram_loader_if #(.BANKS(BANKS), .DATA_W(DW), .SRAM_AW(SAW), .DRAM_AW(DAW)) bus ();

  input_sram_loader #(
    .BANKS(BANKS), .DATA_W(DW), .SRAM_AW(SAW), .DRAM_AW(DAW),
    .INPUT_START(BASE), .MAX_OUTST(MAXO)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start), .width_i(w_i), .height_i(h_i),
    .channel_i(c_i), .busy_o(busy), .done_o(done), .overflow_o(ovf), .bus(bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BANKS-1:0] cs;
    logic [SAW-1:0]   addr;
    logic [31:0]      data;
    bit               ovf;
    bit               chk;
  } wr_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          live;
  } pend_t;

  wr_t   sb[$];
  pend_t pq[$];
  int    vectors = 0, miscompares = 0;
  int    done_cnt = 0, acc_cnt = 0, lat_cfg = 2;
  bit    rnd_ready = 0;
  bit    exp_ovf_final = 0;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Placement model: word k is row k/w overall, row (k/w)%h within its channel.
  task automatic build_expect(int w, int h, int c);
    int  ptr[BANKS];
    bit  of = 0;
    wr_t e;
    int  wrap = (1 << SAW) - 1;
    for (int b = 0; b < BANKS; b++) ptr[b] = 0;
    for (int k = 0; k < w * h * c; k++) begin
      int r = (k / w) % h;
      int b = r % BANKS;
      e.cs      = '0;
      e.cs[b]   = 1'b1;
      e.addr    = SAW'(ptr[b]);
      e.chk     = (ptr[b] != wrap);
      if (ptr[b] == wrap) of = 1;
      e.ovf     = of;
      ptr[b]    = (ptr[b] + 1) % (1 << SAW);
      e.data    = mem_word(BASE + 32'(4 * k));
      sb.push_back(e);
    end
    exp_ovf_final = of;
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_overflow"}, ovf, 0);
    check({tag, "_dram_req"}, bus.dram_req, 0);
    check({tag, "_dram_addr"}, bus.dram_addr, BASE);
    check({tag, "_sram_cs"}, bus.sram_cs, 0);
    check({tag, "_sram_we"}, bus.sram_we, 0);
    check({tag, "_sram_addr"}, bus.sram_addr, 0);
    check({tag, "_sram_wdata"}, bus.sram_wdata, 0);
  endtask

  // DRAM responder: in-order replies after lat_cfg cycles, optional random stalls.
  initial begin
    int  cyc = 0, outst_m = 0;
    bit  cur_live = 0;
    bit  acc, rv;
    pend_t p;
    bus.dram_ready  = 1'b0;
    bus.dram_rvalid = 1'b0;
    bus.dram_rdata  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        foreach (pq[i]) pq[i].live = 0;
        outst_m = 0;
        acc_cnt = 0;
      end else begin
        if (start && !busy) acc_cnt = 0;
        acc = bus.dram_req && bus.dram_ready;
        rv  = bus.dram_rvalid && cur_live;
        if (acc) begin
          check("outstanding_limit", outst_m < MAXO, 1);
          check("dram_addr", bus.dram_addr, BASE + 32'(4 * acc_cnt));
          pq.push_back('{addr: bus.dram_addr, due: cyc + lat_cfg, live: 1'b1});
          acc_cnt++;
        end
        outst_m = outst_m + (acc ? 1 : 0) - (rv ? 1 : 0);
      end
      @(posedge clk);
      #1;
      bus.dram_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pq.size() > 0 && pq[0].due <= cyc + 1) begin
        p = pq.pop_front();
        bus.dram_rvalid = 1'b1;
        bus.dram_rdata  = mem_word(p.addr);
        cur_live        = p.live;
      end else begin
        bus.dram_rvalid = 1'b0;
        bus.dram_rdata  = $urandom;
        cur_live        = 0;
      end
    end
  end

  // SRAM write monitor: every write must match the next expected placement.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
      end else begin
        if (done) done_cnt++;
        if (bus.sram_we) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: got cs=%0h addr=%0h, expected no write",
                     bus.sram_cs, bus.sram_addr);
          end else begin
            e = sb.pop_front();
            check("sram_cs", bus.sram_cs, e.cs);
            check("sram_addr", bus.sram_addr, e.addr);
            check("sram_wdata", bus.sram_wdata, e.data);
            if (e.chk) check("overflow_during_load", ovf, e.ovf);
          end
        end
      end
    end
  end

  task automatic run_load(int w, int h, int c, int lat, bit rr, bit poke);
    int n = w * h * c;
    int d0, t;
    int budget = n * 12 + 100;
    lat_cfg   = lat;
    rnd_ready = rr;
    build_expect(w, h, c);
    @(posedge clk); #1;
    start = 1'b1; w_i = 10'(w); h_i = 10'(h); c_i = 10'(c);
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("overflow_cleared", ovf, 0);
    t = 0;
    if (poke) begin
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1; w_i = 10'd1; h_i = 10'd1; c_i = 10'd1;
      @(posedge clk); #1;
      start = 1'b0;
      t = 4;
    end
    while (done_cnt == d0 && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= budget) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected done", t);
    end
    if (n == 0) check("zero_done_latency", t <= 2, 1);
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", done_cnt - d0, 1);
    check("busy_idle", busy, 0);
    check("writes_left", sb.size(), 0);
    check("requests", acc_cnt, n);
    check("overflow_final", ovf, exp_ovf_final);
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;

    run_load(4, 3, 1, 2, 0, 0);
    run_load(2, 10, 3, 3, 0, 0);
    run_load(5, 7, 2, 6, 1, 1);
    run_load(3, 2, 0, 2, 0, 0);
    for (int i = 0; i < 4; i++) begin
      run_load($urandom_range(1, 9), $urandom_range(1, 12), $urandom_range(1, 3),
               $urandom_range(1, 6), 1, 0);
    end

    // Abort a load after five accepted reads, then let stale replies arrive.
    lat_cfg   = 6;
    rnd_ready = 0;
    build_expect(8, 4, 2);
    @(posedge clk); #1;
    start = 1'b1; w_i = 10'd8; h_i = 10'd4; c_i = 10'd2;
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    while (acc_cnt < 5 && t < 50) begin
      @(posedge clk); #2;
      t++;
    end
    check("accepts_before_reset", acc_cnt >= 5, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("midreset");
    rst = 1'b0;
    repeat (20) @(posedge clk);
    check("stale_drained", pq.size(), 0);
    run_load(3, 2, 2, 2, 0, 0);

    run_load(1023, 1, 17, 2, 0, 0);
    run_load(2, 2, 1, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
